// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: LED channel mode encodings
// and the effective-period helper used by the prescaler and pulse channels.
package gpio_ctrl_pkg;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_BLINK = 2'b01;
    localparam logic [1:0] MODE_PULSE = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    // A programmed period of 0 behaves as 1 so the prescaler always wraps.
    function automatic logic [31:0] eff_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One expansion input bit: two-flop synchroniser, stability counter and a
// one-cycle pulse on each debounced rising transition.
module gpio_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic exp_in,
    output logic exp_out,
    output logic exp_rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // The level is accepted only after s2 has disagreed with exp_out for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            exp_out  <= 1'b0;
            exp_rise <= 1'b0;
        end else begin
            s1       <= exp_in;
            s2       <= s1;
            exp_rise <= 1'b0;
            if (s2 == exp_out) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                exp_out  <= s2;
                exp_rise <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_led_chan.sv
// One LED channel: led_in edge register, blink toggle, retriggerable pulse
// counter and the registered output mux selecting between them.
module gpio_led_chan
    import gpio_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led_in,
    input  logic [1:0]           mode,
    input  logic                 tick,
    input  logic [CNT_WIDTH-1:0] p_eff,
    output logic                 led_out
);

    logic                 led_q;
    logic                 tog;
    logic                 tog_next;
    logic [CNT_WIDTH-1:0] pcnt;
    logic [CNT_WIDTH-1:0] pcnt_next;
    logic                 rise;
    logic                 out_next;

    // Next-state: toggle and pulse counter only live while their mode is selected.
    always_comb begin
        rise      = led_in & ~led_q;
        tog_next  = 1'b0;
        pcnt_next = '0;
        out_next  = 1'b0;
        if (mode == MODE_BLINK) begin
            tog_next = tog ^ tick;
        end
        if (mode == MODE_PULSE) begin
            if (rise) begin
                pcnt_next = p_eff;
            end else if (pcnt != '0) begin
                pcnt_next = pcnt - CNT_WIDTH'(1);
            end
        end
        case (mode)
            MODE_PASS:  out_next = led_in;
            MODE_BLINK: out_next = tog_next;
            MODE_PULSE: out_next = (pcnt_next != '0);
            default:    out_next = 1'b0;
        endcase
    end

    // Channel state and registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= 1'b0;
            tog     <= 1'b0;
            pcnt    <= '0;
            led_out <= 1'b0;
        end else begin
            led_q   <= led_in;
            tog     <= tog_next;
            pcnt    <= pcnt_next;
            led_out <= out_next;
        end
    end

endmodule

// File: rtl/gpio_ctrl_seq.sv
// GPIO controller top: shared blink/pulse prescaler, per-channel LED logic
// and per-bit expansion input conditioning.
module gpio_ctrl_seq
    import gpio_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 24,
    parameter int DEB_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   led_in,
    input  logic [2*DATA_WIDTH-1:0] led_mode,
    input  logic [CNT_WIDTH-1:0]    period,
    output logic [DATA_WIDTH-1:0]   led_out,
    input  logic [DATA_WIDTH-1:0]   exp_in,
    output logic [DATA_WIDTH-1:0]   exp_out,
    output logic [DATA_WIDTH-1:0]   exp_rise
);

    logic [CNT_WIDTH-1:0] presc;
    logic [CNT_WIDTH-1:0] p_eff;
    logic                 tick;

    // Ticking on >= lets a shortened period take effect on the very next cycle.
    always_comb begin
        p_eff = CNT_WIDTH'(eff_period(32'(period)));
        tick  = (presc >= (p_eff - CNT_WIDTH'(1)));
    end

    // Shared prescaler counting 0..P-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + CNT_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        gpio_led_chan #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .led_in (led_in[i]),
            .mode   (led_mode[2*i +: 2]),
            .tick   (tick),
            .p_eff  (p_eff),
            .led_out(led_out[i])
        );

        gpio_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .exp_in  (exp_in[i]),
            .exp_out (exp_out[i]),
            .exp_rise(exp_rise[i])
        );
    end

endmodule

// File: tb/tb_gpio_ctrl_seq.sv
// Bench for gpio_ctrl_seq: PASS/OFF vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_gpio_ctrl_seq;

    localparam int DW  = 8;
    localparam int CW  = 24;
    localparam int DEB = 4;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   led_in;
    logic [2*DW-1:0] led_mode;
    logic [CW-1:0]   period;
    logic [DW-1:0]   exp_in;
    logic [DW-1:0]   led_out;
    logic [DW-1:0]   exp_out;
    logic [DW-1:0]   exp_rise;

    always #5 clk = ~clk;

    gpio_ctrl_seq #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_in  (led_in),
        .led_mode(led_mode),
        .period  (period),
        .led_out (led_out),
        .exp_in  (exp_in),
        .exp_out (exp_out),
        .exp_rise(exp_rise)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_presc;
    logic [DW-1:0] m_led, m_exp, m_rise, m_prev, m_s1, m_s2;
    int            m_rem[DW];
    bit            m_tog[DW];
    int            m_deb[DW];

    task automatic model_step();
        int       p;
        bit       tk;
        bit [1:0] md;
        if (rst) begin
            m_presc = 0;
            m_led = '0; m_exp = '0; m_rise = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
            for (int i = 0; i < DW; i++) begin
                m_rem[i] = 0; m_tog[i] = 0; m_deb[i] = 0;
            end
        end else begin
            p  = (period == 0) ? 1 : int'(period);
            tk = (m_presc >= p - 1);
            m_presc = tk ? 0 : m_presc + 1;
            for (int i = 0; i < DW; i++) begin
                md = led_mode[2*i +: 2];
                case (md)
                    2'b00: m_led[i] = led_in[i];
                    2'b01: begin
                        if (tk) m_tog[i] = !m_tog[i];
                        m_led[i] = m_tog[i];
                    end
                    2'b10: begin
                        if (led_in[i] && !m_prev[i]) m_rem[i] = p;
                        else if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
                        m_led[i] = (m_rem[i] > 0);
                    end
                    default: m_led[i] = 1'b0;
                endcase
                if (md != 2'b01) m_tog[i] = 0;
                if (md != 2'b10) m_rem[i] = 0;
                m_prev[i] = led_in[i];
            end
            m_rise = '0;
            for (int i = 0; i < DW; i++) begin
                if (m_s2[i] != m_exp[i]) begin
                    m_deb[i] = m_deb[i] + 1;
                    if (m_deb[i] == DEB) begin
                        m_exp[i]  = m_s2[i];
                        m_rise[i] = m_s2[i];
                        m_deb[i]  = 0;
                    end
                end else begin
                    m_deb[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = exp_in;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0]   in;
        logic [2*DW-1:0] mode;
        logic [DW-1:0]   exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [8:0] pat;
        rst = 1'b1; led_in = '0; led_mode = '0; period = '0; exp_in = '0;
        @(negedge clk);

        // Reset: all inputs high, PASS mode; outputs stay 0 in reset.
        led_in = '1; exp_in = '1; led_mode = '0; period = '1; rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_led", 32'(led_out), 32'h0);
            chk("rst_exp_out", 32'(exp_out), 32'h0);
            chk("rst_exp_rise", 32'(exp_rise), 32'h0);
        end
        rst = 1'b0;
        cyc();
        chk("rst_release_led", 32'(led_out), 32'hFF);

        // PASS/OFF vector table: output one cycle after the inputs.
        vecs[0] = '{8'h5A, 16'h0000, 8'h5A};
        vecs[1] = '{8'hA5, 16'hFFFF, 8'h00};
        vecs[2] = '{8'hFF, 16'h3333, 8'hAA};
        vecs[3] = '{8'h0F, 16'hCCCC, 8'h05};
        vecs[4] = '{8'hC3, 16'h0000, 8'hC3};
        exp_in = '0;
        for (int v = 0; v < 5; v++) begin
            led_in = vecs[v].in; led_mode = vecs[v].mode;
            cyc();
            chk("vec_pass_off", 32'(led_out), 32'(vecs[v].exp));
        end

        // PULSE: period 5, single edge then retrigger 3 cycles later.
        led_in = '0; led_mode = 16'h0002; period = 5;
        do_reset(2);
        cyc(); cyc();
        led_in = 8'h01;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("pulse_single", 32'(led_out[0]), 32'(k <= 5));
        end
        led_in = '0;
        repeat (3) cyc();
        led_in = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("pulse_retrig", 32'(led_out[0]), 32'(k <= 8));
            if (k == 1) led_in = 8'h00;
            if (k == 3) led_in = 8'h01;
        end

        // BLINK: period 3 gives a 6-cycle square wave on channel 1.
        led_in = '0; led_mode = 16'h0004; period = 3;
        do_reset(2);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("blink_p3", 32'(led_out[1]), 32'((k / 3) % 2));
        end
        // BLINK with period 0 toggles every cycle.
        period = 0;
        do_reset(2);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("blink_p0", 32'(led_out[1]), 32'(k % 2));
        end

        // Mode switch BLINK -> OFF -> BLINK restarts low.
        period = 3; led_mode = 16'h0004;
        do_reset(2);
        pat = 9'b100000100;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("mode_blink_off", 32'(led_out[1]), 32'(pat[k-1]));
            if (k == 3) led_mode = 16'h000C;
            if (k == 6) led_mode = 16'h0004;
        end

        // PULSE -> PASS mid-pulse follows led_in next cycle.
        period = 10; led_mode = 16'h0002; led_in = '0;
        do_reset(2);
        led_in = 8'h01;
        cyc(); chk("pulse_pass_k1", 32'(led_out[0]), 32'h1);
        cyc(); chk("pulse_pass_k2", 32'(led_out[0]), 32'h1);
        led_mode = 16'h0000; led_in = 8'h00;
        cyc(); chk("pulse_pass_lo", 32'(led_out[0]), 32'h0);
        led_in = 8'h01;
        cyc(); chk("pulse_pass_hi", 32'(led_out[0]), 32'h1);
        led_in = 8'h00;
        cyc(); chk("pulse_pass_lo2", 32'(led_out[0]), 32'h0);

        // Debounce: clean step on bit 2 appears 6 cycles after the sampling edge.
        led_mode = '0; led_in = '0; exp_in = '0;
        do_reset(2);
        repeat (2) cyc();
        exp_in = 8'h04;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("deb_out", 32'(exp_out[2]), 32'(k >= 6));
            chk("deb_rise", 32'(exp_rise[2]), 32'(k == 6));
        end
        // 3-cycle glitches (bit 2 low, bit 3 high) must not change anything.
        exp_in = 8'h08;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            chk("deb_glitch_out", 32'(exp_out), 32'h04);
            chk("deb_glitch_rise", 32'(exp_rise), 32'h00);
            if (k == 3) exp_in = 8'h04;
        end

        // Reset mid-pulse and mid-debounce aborts both.
        led_mode = 16'h0002; period = 20; led_in = '0; exp_in = '0;
        do_reset(2);
        led_in = 8'h01;
        repeat (3) cyc();
        chk("midrst_pulse_active", 32'(led_out[0]), 32'h1);
        exp_in = 8'h20;
        repeat (4) cyc();
        chk("midrst_deb_pending", 32'(exp_out), 32'h0);
        rst = 1'b1; led_in = '0; exp_in = '0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("midrst_led", 32'(led_out), 32'h0);
            chk("midrst_exp", 32'(exp_out), 32'h0);
        end
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            chk("postrst_led", 32'(led_out), 32'h0);
            chk("postrst_rise", 32'(exp_rise), 32'h0);
            chk("postrst_exp", 32'(exp_out), 32'h0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) led_in = DW'($urandom);
            if ($urandom_range(0, 15) == 0) led_mode = (2*DW)'($urandom);
            if ($urandom_range(0, 31) == 0) period = CW'($urandom_range(0, 5));
            for (int i = 0; i < DW; i++) begin
                if ($urandom_range(0, 7) == 0) exp_in[i] = ~exp_in[i];
            end
            cyc();
            chk("rand_led", 32'(led_out), 32'(m_led));
            chk("rand_exp_out", 32'(exp_out), 32'(m_exp));
            chk("rand_exp_rise", 32'(exp_rise), 32'(m_rise));
        end

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
